// File: rtl/spi_pkg.sv
// Shared types and constants for the clocked-SS serial link initiator.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECT   = 3'd1,
    CMD      = 3'd2,
    WR_SHIFT = 3'd3,
    WR_HOLD  = 3'd4,
    RD_SHIFT = 3'd5,
    GAP      = 3'd6
  } state_e;

  localparam logic       CMD_WR      = 1'b0;
  localparam logic       CMD_RD      = 1'b1;
  localparam int         DEF_WR_BITS = 10;
  localparam int         DEF_RD_BITS = 8;
  localparam logic [1:0] SS_IDLE     = 2'b11;
  localparam logic [1:0] SS_ACTIVE   = 2'b00;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_if.sv
// Command-side and link-side signals of the serial link initiator.
interface spi_if
  import spi_pkg::*;
#(
  parameter int WR_BITS = DEF_WR_BITS,
  parameter int RD_BITS = DEF_RD_BITS
) ();

  logic               start;
  logic               cmd_rd;
  logic [WR_BITS-1:0] wr_word;
  logic               MISO;
  logic [1:0]         SS_n;
  logic               MOSI;
  logic               busy;
  logic               done;
  logic               rd_valid;
  logic [RD_BITS-1:0] rd_data;

  modport master (
    input  start, cmd_rd, wr_word, MISO,
    output SS_n, MOSI, busy, done, rd_valid, rd_data
  );

  modport slave (
    output start, cmd_rd, wr_word, MISO,
    input  SS_n, MOSI, busy, done, rd_valid, rd_data
  );

endinterface

// File: rtl/spi_shifter.sv
// Frame shift register: parallel load, MSB-first serial out, LSB serial-in capture.
module spi_shifter #(
  parameter int W     = 11,
  parameter int CAP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [W-1:0]     load_val,
  input  logic             shift,
  input  logic             ser_in,
  output logic             ser_out,
  output logic [CAP_W-1:0] cap_word
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_val;
    end else if (shift) begin
      sr_d = {sr_q[W-2:0], ser_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign ser_out  = sr_q[W-1];
  // Includes the bit being sampled this cycle so the final capture needs no extra edge.
  assign cap_word = {sr_q[CAP_W-2:0], ser_in};

endmodule

// File: rtl/spi_master.sv
// Initiator for the clocked-SS link: write and read frames, one bit per clk, all outputs registered.
module spi_master
  import spi_pkg::*;
#(
  parameter int WR_BITS    = DEF_WR_BITS,
  parameter int RD_BITS    = DEF_RD_BITS,
  parameter int GAP_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  spi_if.master bus
);

  localparam int SH_W  = max2(WR_BITS, RD_BITS) + 1;
  localparam int CNT_W = $clog2(max2(max2(WR_BITS, RD_BITS), GAP_CYCLES) + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cmd_q, cmd_d;
  logic [1:0]         ss_q, ss_d;
  logic               mosi_q, mosi_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_valid_q, rd_valid_d;
  logic [RD_BITS-1:0] rd_data_q, rd_data_d;

  logic               sh_load, sh_shift, sh_out;
  logic [SH_W-1:0]    sh_load_val;
  logic [RD_BITS-1:0] sh_cap;

  spi_shifter #(
    .W     (SH_W),
    .CAP_W (RD_BITS)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sh_load),
    .load_val (sh_load_val),
    .shift    (sh_shift),
    .ser_in   (bus.MISO),
    .ser_out  (sh_out),
    .cap_word (sh_cap)
  );

  always_comb begin
    sh_load_val                      = '0;
    sh_load_val[SH_W-1]              = bus.cmd_rd;
    sh_load_val[SH_W-2 -: WR_BITS]   = bus.wr_word;
  end

  // Outputs are computed for the state being entered, so they register alongside it.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    mosi_d     = 1'b0;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SELECT;
          cmd_d   = bus.cmd_rd;
          sh_load = 1'b1;
        end
      end
      SELECT: begin
        state_d  = CMD;
        mosi_d   = sh_out;
        sh_shift = 1'b1;
      end
      CMD: begin
        if (cmd_q == CMD_RD) begin
          state_d = RD_SHIFT;
        end else begin
          state_d  = WR_SHIFT;
          mosi_d   = sh_out;
          sh_shift = 1'b1;
        end
      end
      WR_SHIFT: begin
        if (cnt_q == CNT_W'(WR_BITS - 1)) begin
          state_d = WR_HOLD;
        end else begin
          mosi_d   = sh_out;
          sh_shift = 1'b1;
        end
      end
      WR_HOLD: begin
        state_d = GAP;
        done_d  = 1'b1;
      end
      RD_SHIFT: begin
        sh_shift = 1'b1;
        if (cnt_q == CNT_W'(RD_BITS - 1)) begin
          state_d    = GAP;
          done_d     = 1'b1;
          rd_valid_d = 1'b1;
          rd_data_d  = sh_cap;
        end
      end
      GAP: begin
        // A start seen in the final gap cycle launches the next frame directly,
        // keeping the SS_n-high spacing at exactly GAP_CYCLES.
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          if (bus.start) begin
            state_d = SELECT;
            cmd_d   = bus.cmd_rd;
            sh_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        cmd_d     = 1'b0;
        rd_data_d = '0;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    case (state_d)
      SELECT, CMD, WR_SHIFT, WR_HOLD, RD_SHIFT: ss_d = SS_ACTIVE;
      default:                                  ss_d = SS_IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cmd_q      <= 1'b0;
      ss_q       <= SS_IDLE;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      ss_q       <= ss_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.SS_n     = ss_q;
  assign bus.MOSI     = mosi_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: behavioural responder/monitor plus frame-level reference model.
module tb_spi_master;
  import spi_pkg::*;

  localparam int WR  = 10;
  localparam int RD  = 8;
  localparam int GAP = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_if #(.WR_BITS(WR), .RD_BITS(RD)) bus ();

  spi_master #(.WR_BITS(WR), .RD_BITS(RD), .GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] vec;
    int          len;
  } frame_t;

  typedef struct {
    logic          cmd;
    logic [WR-1:0] word;
    logic [RD-1:0] resp;
    logic [WR-1:0] exp_rx;
    logic [RD-1:0] exp_rd;
  } vec_t;

  frame_t        frame_q[$];
  int            gap_q[$];
  logic [RD-1:0] resp_byte = '0;
  logic [RD-1:0] last_rd   = '0;
  int            bad_ss    = 0;
  bit            in_frame  = 0;
  bit            seen      = 0;
  logic          frame_cmd = 1'b0;
  logic [31:0]   cur_vec   = '0;
  int            cur_len   = 0;
  int            gap_cnt   = 0;
  int            idx;

  // Link responder: records MOSI per SS_n-low cycle and serves resp_byte MSB first on reads.
  always @(negedge clk) begin
    if (bus.SS_n !== 2'b00 && bus.SS_n !== 2'b11) bad_ss++;
    if (bus.SS_n == 2'b00) begin
      if (!in_frame) begin
        in_frame = 1;
        cur_vec  = '0;
        cur_len  = 0;
        if (seen) gap_q.push_back(gap_cnt);
      end
      cur_vec = {cur_vec[30:0], bus.MOSI};
      cur_len++;
      idx = cur_len - 1;
      if (idx == 1) frame_cmd = bus.MOSI;
      if (frame_cmd && idx >= 2 && idx < 2 + RD) bus.MISO = resp_byte[RD-1-(idx-2)];
      else bus.MISO = 1'b0;
    end else begin
      if (in_frame) begin
        in_frame = 0;
        frame_q.push_back('{vec: cur_vec, len: cur_len});
        seen    = 1;
        gap_cnt = 0;
      end
      gap_cnt++;
      bus.MISO  = 1'b0;
      frame_cmd = 1'b0;
    end
  end

  function automatic int exp_len(input logic cmd);
    return cmd ? RD + 2 : WR + 3;
  endfunction

  function automatic logic [31:0] exp_mosi(input logic cmd, input logic [WR-1:0] word);
    return cmd ? (32'd1 << RD) : ({22'd0, word} << 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic cmd, input logic [WR-1:0] word, input logic [RD-1:0] resp,
                               output int lat);
    resp_byte = resp;
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.cmd_rd  = cmd;
    bus.wr_word = word;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) bus.start = 1'b0;
    end while (bus.done !== 1'b1 && lat < 200);
  endtask

  task automatic run_frame(input string name, input logic cmd, input logic [WR-1:0] word,
                           input logic [RD-1:0] resp);
    int     lat;
    frame_t f;
    applyStimulus(cmd, word, resp, lat);
    if (cmd) last_rd = resp;
    checkOutput({name, ".latency"}, lat, exp_len(cmd) + 1);
    checkOutput({name, ".rd_valid"}, {31'd0, bus.rd_valid}, {31'd0, cmd});
    checkOutput({name, ".rd_data"}, {24'd0, bus.rd_data}, {24'd0, last_rd});
    checkOutput({name, ".busy_gap"}, {31'd0, bus.busy}, 32'd1);
    @(negedge clk); #1;
    checkOutput({name, ".frames"}, frame_q.size(), 1);
    if (frame_q.size() > 0) begin
      f = frame_q.pop_front();
      checkOutput({name, ".len"}, f.len, exp_len(cmd));
      checkOutput({name, ".mosi"}, f.vec, exp_mosi(cmd, word));
      if (!cmd) checkOutput({name, ".rx_data"}, (f.vec >> 1) & 32'h3FF, {22'd0, word});
    end
    frame_q.delete();
    @(posedge clk); #1;
    checkOutput({name, ".busy_idle"}, {31'd0, bus.busy}, 32'd0);
    checkOutput({name, ".done_pulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    vec_t   tbl[5];
    int     n, n2, dcount;
    logic [WR-1:0] orig;
    frame_t f;

    tbl[0] = '{cmd: 1'b0, word: 10'h2A5, resp: 8'h00, exp_rx: 10'h2A5, exp_rd: 8'h00};
    tbl[1] = '{cmd: 1'b1, word: 10'h000, resp: 8'hC3, exp_rx: 10'h000, exp_rd: 8'hC3};
    tbl[2] = '{cmd: 1'b0, word: 10'h3FF, resp: 8'h00, exp_rx: 10'h3FF, exp_rd: 8'hC3};
    tbl[3] = '{cmd: 1'b0, word: 10'h001, resp: 8'h00, exp_rx: 10'h001, exp_rd: 8'hC3};
    tbl[4] = '{cmd: 1'b1, word: 10'h155, resp: 8'h5A, exp_rx: 10'h000, exp_rd: 8'h5A};

    bus.start = 1'b0; bus.cmd_rd = 1'b0; bus.wr_word = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #20;
    checkOutput("reset.SS_n", {30'd0, bus.SS_n}, 32'd3);
    checkOutput("reset.MOSI", {31'd0, bus.MOSI}, 32'd0);
    checkOutput("reset.busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset.done", {31'd0, bus.done}, 32'd0);
    checkOutput("reset.rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    checkOutput("reset.rd_data", {24'd0, bus.rd_data}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    frame_q.delete();

    for (int i = 0; i < 5; i++) begin
      run_frame($sformatf("table%0d", i), tbl[i].cmd, tbl[i].word, tbl[i].resp);
      checkOutput($sformatf("table%0d.exp_rd", i), {24'd0, bus.rd_data}, {24'd0, tbl[i].exp_rd});
    end

    for (int i = 0; i < 16; i++) begin
      run_frame($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), WR'($urandom), RD'($urandom));
    end

    // Back-to-back with start held high; mid-frame cmd/word changes must not leak into frame one.
    frame_q.delete(); gap_q.delete();
    resp_byte = 8'h96;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.cmd_rd = 1'b0; bus.wr_word = 10'h155;
    @(posedge clk); #1;
    bus.cmd_rd = 1'b1; bus.wr_word = 10'h0AA;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (bus.done !== 1'b1 && n < 200);
    checkOutput("b2b.first_done", n, exp_len(1'b0));
    @(posedge clk); #1;
    bus.start = 1'b0;
    n2 = 0;
    do begin @(posedge clk); #1; n2++; end while (bus.done !== 1'b1 && n2 < 200);
    checkOutput("b2b.second_done", n2, exp_len(1'b1));
    checkOutput("b2b.rd_valid", {31'd0, bus.rd_valid}, 32'd1);
    checkOutput("b2b.rd_data", {24'd0, bus.rd_data}, 32'h96);
    last_rd = 8'h96;
    @(negedge clk); #1;
    checkOutput("b2b.frames", frame_q.size(), 2);
    if (frame_q.size() >= 2) begin
      checkOutput("b2b.mosi0", frame_q[0].vec, exp_mosi(1'b0, 10'h155));
      checkOutput("b2b.mosi1", frame_q[1].vec, exp_mosi(1'b1, 10'h000));
    end
    checkOutput("b2b.gap_seen", {31'd0, gap_q.size() > 0}, 32'd1);
    if (gap_q.size() > 0) checkOutput("b2b.gap", gap_q[gap_q.size()-1], GAP);
    frame_q.delete();
    repeat (3) @(posedge clk);

    // Start pulses and input churn while busy are ignored.
    orig = 10'h1C3;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.cmd_rd = 1'b0; bus.wr_word = orig;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      n++;
      bus.start   = i[0];
      bus.wr_word = WR'($urandom);
      bus.cmd_rd  = 1'($urandom_range(0, 1));
    end
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    checkOutput("busy_start.latency", n, exp_len(1'b0) + 1);
    @(negedge clk); #1;
    checkOutput("busy_start.frames", frame_q.size(), 1);
    if (frame_q.size() > 0) begin
      f = frame_q.pop_front();
      checkOutput("busy_start.mosi", f.vec, exp_mosi(1'b0, orig));
    end
    dcount = 0;
    repeat (20) begin @(posedge clk); #1; if (bus.done === 1'b1) dcount++; end
    checkOutput("busy_start.extra_done", dcount, 0);
    checkOutput("busy_start.extra_frames", frame_q.size(), 0);

    // Asynchronous reset in the middle of a write payload.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.cmd_rd = 1'b0; bus.wr_word = 10'h2A5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("rstmid.in_frame", {30'd0, bus.SS_n}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstmid.SS_n", {30'd0, bus.SS_n}, 32'd3);
    checkOutput("rstmid.MOSI", {31'd0, bus.MOSI}, 32'd0);
    checkOutput("rstmid.busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rstmid.rd_data", {24'd0, bus.rd_data}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    last_rd = '0;
    dcount = 0;
    repeat (30) begin @(posedge clk); #1; if (bus.done === 1'b1) dcount++; end
    checkOutput("rstmid.no_done", dcount, 0);
    frame_q.delete();

    run_frame("post_reset", 1'b0, 10'h0F0, 8'h00);
    checkOutput("ss_encoding", bad_ss, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
